// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and the TX state encoding.
package mmio_uart_tx_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_BAUD   = 4'h8;
    localparam logic [3:0] OFF_RSVD   = 4'hC;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [3:0] sat_count(input logic [31:0] c);
        logic [3:0] r;
        if (c > 32'd15) r = 4'hF;
        else            r = c[3:0];
        return r;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous TX byte FIFO with combinational head output.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, registers and the
// serialiser FSM; bytes are queued in uart_tx_fifo.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0020,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          DIV_WIDTH   = 16,
    parameter int          DEFAULT_DIV = 868,
    localparam int         AW          = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write_i,
    input  logic        mem_read_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        sel_o,
    output logic        tx_o,
    output logic        irq_o
);

    tx_state_e            r_state;
    tx_state_e            w_state_n;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_n;
    logic [DIV_WIDTH-1:0] r_period;
    logic [DIV_WIDTH-1:0] w_period_n;
    logic [DIV_WIDTH-1:0] r_bcnt;
    logic [DIV_WIDTH-1:0] w_bcnt_n;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit_n;
    logic                 r_tx;
    logic                 w_tx_n;
    logic                 r_irq;
    logic [DIV_WIDTH-1:0] r_baud;
    logic                 r_ovf;

    logic                 w_sel;
    logic [3:0]           w_off;
    logic                 w_wr;
    logic                 w_push_req;
    logic                 w_push_ok;
    logic                 w_pop;
    logic                 w_tick;
    logic [7:0]           w_dout;
    logic                 w_full;
    logic                 w_empty;
    logic [AW:0]          w_count;
    logic [7:0]           w_status;
    logic [31:0]          w_rdata;
    logic [DIV_WIDTH-1:0] w_div_wr;
    logic                 w_unused;

    assign w_sel      = (address_i[31:4] == BASE_ADDR[31:4]);
    assign w_off      = {address_i[3:2], 2'b00};
    assign w_wr       = mem_write_i && w_sel;
    assign w_push_req = w_wr && (w_off == OFF_TXDATA);
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_div_wr   = write_data_i[DIV_WIDTH-1:0];
    assign w_unused   = ^{address_i[1:0], write_data_i};

    assign sel_o       = w_sel;
    assign read_data_o = w_rdata;
    assign tx_o        = r_tx;
    assign irq_o       = r_irq;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_ok),
        .i_pop   (w_pop),
        .i_din   (write_data_i[7:0]),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status             = '0;
        w_status[ST_BUSY]    = (r_state != S_IDLE);
        w_status[ST_FULL]    = w_full;
        w_status[ST_EMPTY]   = w_empty;
        w_status[ST_OVF]     = r_ovf;
        w_status[7:ST_CNT_LSB] = sat_count(32'(w_count));
    end

    always_comb begin
        w_rdata = '0;
        if (mem_read_i && w_sel) begin
            case (w_off)
                OFF_STATUS: w_rdata = {24'b0, w_status};
                OFF_BAUD:   w_rdata = 32'(r_baud);
                default:    w_rdata = '0;
            endcase
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_shift_n  = r_shift;
        w_period_n = r_period;
        w_bcnt_n   = r_bcnt;
        w_bit_n    = r_bit;
        w_pop      = 1'b0;
        w_tick     = (r_bcnt == r_period - DIV_WIDTH'(1));
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_n  = w_dout;
                    w_period_n = r_baud;
                    w_bcnt_n   = '0;
                    w_state_n  = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_bcnt_n  = '0;
                    w_bit_n   = '0;
                    w_state_n = S_DATA;
                end else begin
                    w_bcnt_n = r_bcnt + DIV_WIDTH'(1);
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_bcnt_n  = '0;
                    w_shift_n = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_n = S_STOP;
                    else               w_bit_n   = r_bit + 3'd1;
                end else begin
                    w_bcnt_n = r_bcnt + DIV_WIDTH'(1);
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_bcnt_n = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_n  = w_dout;
                        w_period_n = r_baud;
                        w_state_n  = S_START;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else begin
                    w_bcnt_n = r_bcnt + DIV_WIDTH'(1);
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        unique case (w_state_n)
            S_START: w_tx_n = 1'b0;
            S_DATA:  w_tx_n = w_shift_n[0];
            default: w_tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_period <= DIV_WIDTH'(DEFAULT_DIV);
            r_bcnt   <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b1;
            r_irq    <= 1'b1;
        end else begin
            r_state  <= w_state_n;
            r_shift  <= w_shift_n;
            r_period <= w_period_n;
            r_bcnt   <= w_bcnt_n;
            r_bit    <= w_bit_n;
            r_tx     <= w_tx_n;
            // Entering IDLE implies the FIFO is empty unless a push lands now.
            r_irq    <= (w_state_n == S_IDLE) && !w_push_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud <= DIV_WIDTH'(DEFAULT_DIV);
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr && (w_off == OFF_BAUD)) begin
                r_baud <= (w_div_wr == '0) ? DIV_WIDTH'(1) : w_div_wr;
            end
            if (w_push_req && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_off == OFF_STATUS) && write_data_i[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule
